// File: rtl/dm_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Optional feature macro: DM_BYTE_EN (per-byte write enables on the bus).
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmState_t;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned WORD_BYTES  = 4;
    // Wide enough to hold LATENCY_MAX - 1.
    localparam int unsigned CNT_W       = 4;

    // Word-index width for a given storage depth (at least one bit).
    function automatic int unsigned idxWidth(input int unsigned depthWords);
        return (depthWords <= 1) ? 1 : $clog2(depthWords);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the CPU pipeline (master) and the
// data-memory responder (slave). MemByteEn exists only when DM_BYTE_EN is defined.
interface data_mem_responder_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
`ifdef DM_BYTE_EN
    logic [3:0]  MemByteEn;
`endif
    logic [31:0] MemReadData;
    logic        MemReady;
    logic        MemStall;
    logic        MisalignErr;

    modport master (
`ifdef DM_BYTE_EN
        output MemByteEn,
`endif
        output MemRead,
        output MemWrite,
        output MemAddr,
        output MemWriteData,
        input  MemReadData,
        input  MemReady,
        input  MemStall,
        input  MisalignErr
    );

    modport slave (
`ifdef DM_BYTE_EN
        input  MemByteEn,
`endif
        input  MemRead,
        input  MemWrite,
        input  MemAddr,
        input  MemWriteData,
        output MemReadData,
        output MemReady,
        output MemStall,
        output MisalignErr
    );

endinterface

// File: rtl/dm_array.sv
// Word storage: synchronous write, registered read. The read register loads
// either the addressed word or zero, so the responder can return 0 for
// writes and misaligned loads. Storage itself is never cleared.
// Optional feature macro: DM_BYTE_EN (wrBe[i] enables wrData[8*i+7:8*i]).
module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = idxWidth(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wrData,
`ifdef DM_BYTE_EN
    input  logic [3:0]       wrBe,
`endif
    input  logic             rdLoad,
    input  logic             rdSel,
    output logic [31:0]      rdData
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdQ;

`ifdef DM_BYTE_EN
    // Byte-lane write; a zero mask completes without changing the word.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wrBe[i]) begin
                    mem[idx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end
`else
    // Full-word write.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[idx] <= wrData;
        end
    end
`endif

    // Read register: addressed word or zero, captured on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdQ <= '0;
        end else if (rdLoad) begin
            rdQ <= rdSel ? mem[idx] : '0;
        end
    end

    assign rdData = rdQ;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Samples a load/store,
// stalls the pipeline for LATENCY cycles, then pulses MemReady for one cycle.
// Optional feature macro: DM_BYTE_EN (adds MemByteEn lane enables).
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = idxWidth(DEPTH_WORDS);
    localparam int unsigned OFF_W = $clog2(WORD_BYTES);
    // Out-of-range latencies are pulled into the legal window.
    localparam int unsigned LAT   = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                                    (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    dmState_t         stateQ;
    logic [CNT_W-1:0] cntQ;
    logic [IDX_W-1:0] idxQ;
    logic [31:0]      wrDataQ;
    logic             isWrQ;
    logic             misQ;
    logic             readyQ;
    logic             misErrQ;
`ifdef DM_BYTE_EN
    logic [3:0]       beQ;
    logic [3:0]       curBe;
`endif

    logic             req;
    logic [IDX_W-1:0] liveIdx;
    logic             liveMis;
    logic [IDX_W-1:0] curIdx;
    logic [31:0]      curData;
    logic             curWr;
    logic             curMis;
    logic             enterDone;
    logic [31:0]      rdData;
    logic             unusedAddr;

    assign req        = bus.MemRead | bus.MemWrite;
    assign liveIdx    = bus.MemAddr[IDX_W+OFF_W-1:OFF_W];
    // Upper address bits are ignored: addresses wrap modulo the storage size.
    assign unusedAddr = ^bus.MemAddr[31:IDX_W+OFF_W];

`ifdef DM_BYTE_EN
    // Misaligned when an enabled lane lies below the addressed byte offset
    // (lane bit 3 is byte offset 0).
    always_comb begin
        liveMis = 1'b0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if ((k < int'(bus.MemAddr[OFF_W-1:0])) && bus.MemByteEn[WORD_BYTES-1-k]) begin
                liveMis = 1'b1;
            end
        end
    end
`else
    // Misaligned unless the address is word aligned.
    always_comb begin
        liveMis = (bus.MemAddr[OFF_W-1:0] != '0);
    end
`endif

    // Request view at the completing edge: live bus in IDLE (LATENCY=1 path),
    // latched copy otherwise.
    always_comb begin
        if (stateQ == IDLE) begin
            curIdx  = liveIdx;
            curData = bus.MemWriteData;
            curWr   = bus.MemWrite;
            curMis  = liveMis;
`ifdef DM_BYTE_EN
            curBe   = bus.MemByteEn;
`endif
        end else begin
            curIdx  = idxQ;
            curData = wrDataQ;
            curWr   = isWrQ;
            curMis  = misQ;
`ifdef DM_BYTE_EN
            curBe   = beQ;
`endif
        end
    end

    assign enterDone = ((stateQ == IDLE) && req && (LAT == 1)) ||
                       ((stateQ == BUSY) && (cntQ == CNT_W'(1)));

    // Request FSM with latency counter and registered completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            idxQ    <= '0;
            wrDataQ <= '0;
            isWrQ   <= 1'b0;
            misQ    <= 1'b0;
            readyQ  <= 1'b0;
            misErrQ <= 1'b0;
`ifdef DM_BYTE_EN
            beQ     <= '0;
`endif
        end else begin
            unique case (stateQ)
                IDLE: begin
                    readyQ <= 1'b0;
                    if (req) begin
                        idxQ    <= liveIdx;
                        wrDataQ <= bus.MemWriteData;
                        isWrQ   <= bus.MemWrite;
                        misQ    <= liveMis;
`ifdef DM_BYTE_EN
                        beQ     <= bus.MemByteEn;
`endif
                        cntQ    <= CNT_INIT;
                        if (LAT == 1) begin
                            stateQ  <= DONE;
                            readyQ  <= 1'b1;
                            misErrQ <= liveMis;
                        end else begin
                            stateQ <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cntQ == CNT_W'(1)) begin
                        stateQ  <= DONE;
                        readyQ  <= 1'b1;
                        misErrQ <= misQ;
                        cntQ    <= '0;
                    end else begin
                        cntQ <= cntQ - CNT_W'(1);
                    end
                end
                DONE: begin
                    stateQ <= IDLE;
                    readyQ <= 1'b0;
                end
                default: begin
                    stateQ <= IDLE;
                    readyQ <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit only on the completing edge; reset drops a pending write.
    dm_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) uArray (
        .clk   (clk),
        .rst   (rst),
        .wrEn  (enterDone & curWr & ~curMis & ~rst),
        .idx   (curIdx),
        .wrData(curData),
`ifdef DM_BYTE_EN
        .wrBe  (curBe),
`endif
        .rdLoad(enterDone),
        .rdSel (~curWr & ~curMis),
        .rdData(rdData)
    );

    assign bus.MemReadData = rdData;
    assign bus.MemReady    = readyQ;
    assign bus.MisalignErr = misErrQ;
    assign bus.MemStall    = req & ~readyQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with LATENCY 1, 2, 3
// and 15 share one stimulus driver selected by 'sel'.
module tb_data_mem_responder;

    localparam int unsigned LATS [4] = '{1, 2, 3, 15};

    logic clk;
    logic rst;
    int   sel;
    logic rdIn;
    logic wrIn;
    logic [31:0] addrIn;
    logic [31:0] dataIn;
`ifdef DM_BYTE_EN
    logic [3:0]  beIn;
`endif

    logic [3:0]  rdyV;
    logic [3:0]  stallV;
    logic [3:0]  misV;
    logic [31:0] rdataV [4];

    int checks;
    int errors;

    data_mem_responder_if bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : gDut
        assign bus[g].MemRead      = (sel == g) && rdIn;
        assign bus[g].MemWrite     = (sel == g) && wrIn;
        assign bus[g].MemAddr      = addrIn;
        assign bus[g].MemWriteData = dataIn;
`ifdef DM_BYTE_EN
        assign bus[g].MemByteEn    = beIn;
`endif
        data_mem_responder #(
            .DEPTH_WORDS(64),
            .LATENCY    (LATS[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );
        assign rdyV[g]   = bus[g].MemReady;
        assign stallV[g] = bus[g].MemStall;
        assign misV[g]   = bus[g].MisalignErr;
        assign rdataV[g] = bus[g].MemReadData;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access: request in cycle 0, held until the MemReady cycle, dropped after.
    task automatic doAccess(input int s, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input int expLat, input logic [31:0] expData,
                            input logic expMis, input string tag);
        int lat;
        int stallCnt;
        sel    = s;
        rdIn   = r;
        wrIn   = w;
        addrIn = a;
        dataIn = d;
        #1;
        lat      = 0;
        stallCnt = 0;
        while (!rdyV[s] && lat < 40) begin
            if (stallV[s]) stallCnt++;
            tick();
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, expLat);
        chk($sformatf("%s stallCycles", tag), stallCnt, expLat);
        chk($sformatf("%s stallInDone", tag), {31'b0, stallV[s]}, 32'd0);
        chk($sformatf("%s misalign", tag), {31'b0, misV[s]}, {31'b0, expMis});
        chk($sformatf("%s readData", tag), rdataV[s], expData);
        tick();
        rdIn = 1'b0;
        wrIn = 1'b0;
    endtask

    initial begin
        int sawReady;
        checks = 0;
        errors = 0;
        sel    = 0;
        rdIn   = 1'b0;
        wrIn   = 1'b0;
        addrIn = '0;
        dataIn = '0;
`ifdef DM_BYTE_EN
        beIn   = 4'b1111;
`endif
        rst    = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset%0d ready", s), {31'b0, rdyV[s]}, 32'd0);
            chk($sformatf("reset%0d misalign", s), {31'b0, misV[s]}, 32'd0);
            chk($sformatf("reset%0d readData", s), rdataV[s], 32'd0);
            chk($sformatf("reset%0d stall", s), {31'b0, stallV[s]}, 32'd0);
        end
        rst = 1'b0;
        tick();

        // Basic write then back-to-back read, LATENCY=2.
        doAccess(1, 1'b0, 1'b1, 32'h08, 32'h12345678, 2, 32'h0, 1'b0, "basicWr");
        doAccess(1, 1'b1, 1'b0, 32'h08, 32'h0, 2, 32'h12345678, 1'b0, "basicRd");

        // Reset in the cycle after a write request, LATENCY=3.
        doAccess(2, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 3, 32'h0, 1'b0, "priorWr");
        sel    = 2;
        wrIn   = 1'b1;
        addrIn = 32'h10;
        dataIn = 32'hDEADBEEF;
        #1;
        chk("rstMid stallReq", {31'b0, stallV[2]}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        wrIn = 1'b0;
        #1;
        chk("rstMid stallAfter", {31'b0, stallV[2]}, 32'd0);
        sawReady = 0;
        for (int i = 0; i < 5; i++) begin
            if (rdyV[2]) sawReady++;
            tick();
        end
        chk("rstMid noReady", sawReady, 0);
        doAccess(2, 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'h0BADF00D, 1'b0, "rstMidRd");

        // Latency sweep at the extremes.
        doAccess(0, 1'b0, 1'b1, 32'h00, 32'hCAFE0001, 1, 32'h0, 1'b0, "lat1Wr");
        doAccess(0, 1'b1, 1'b0, 32'h00, 32'h0, 1, 32'hCAFE0001, 1'b0, "lat1Rd");
        doAccess(3, 1'b0, 1'b1, 32'h00, 32'hCAFE000F, 15, 32'h0, 1'b0, "lat15Wr");
        doAccess(3, 1'b1, 1'b0, 32'h00, 32'h0, 15, 32'hCAFE000F, 1'b0, "lat15Rd");

        // Misaligned read and write leave storage untouched.
        doAccess(1, 1'b0, 1'b1, 32'h04, 32'h44445555, 2, 32'h0, 1'b0, "misSetup");
        doAccess(1, 1'b1, 1'b0, 32'h04, 32'h0, 2, 32'h44445555, 1'b0, "misPreRd");
        doAccess(1, 1'b1, 1'b0, 32'h06, 32'h0, 2, 32'h0, 1'b1, "misRd06");
        doAccess(1, 1'b0, 1'b1, 32'h05, 32'hFFFFFFFF, 2, 32'h0, 1'b1, "misWr05");
        doAccess(1, 1'b1, 1'b0, 32'h04, 32'h0, 2, 32'h44445555, 1'b0, "misPostRd");

        // Wrap-around: 0x100 aliases 0x000 with 64 words.
        doAccess(1, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 2, 32'h0, 1'b0, "wrapWr");
        doAccess(1, 1'b1, 1'b0, 32'h000, 32'h0, 2, 32'hA5A5A5A5, 1'b0, "wrapRd");

        // Read and write together behave as a write.
        doAccess(1, 1'b1, 1'b1, 32'h20, 32'h00000001, 2, 32'h0, 1'b0, "dualReq");
        doAccess(1, 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h00000001, 1'b0, "dualRd");

`ifdef DM_BYTE_EN
        // Single-lane write into byte offset 1, then an all-disabled write.
        doAccess(1, 1'b0, 1'b1, 32'h0C, 32'h11223344, 2, 32'h0, 1'b0, "beFull");
        beIn = 4'b0100;
        doAccess(1, 1'b0, 1'b1, 32'h0C, 32'hAABBCCDD, 2, 32'h0, 1'b0, "beLane");
        beIn = 4'b0000;
        doAccess(1, 1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 2, 32'h0, 1'b0, "beNone");
        beIn = 4'b1111;
        doAccess(1, 1'b1, 1'b0, 32'h0C, 32'h0, 2, 32'h11BB3344, 1'b0, "beRd");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
